// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arb_mux round-robin multiplexer.
package arb_mux_pkg;

  localparam int unsigned ARB_MUX_MAX_CHANNELS = 16;

  // Wide enough for any legal channel index.
  typedef logic [$clog2(ARB_MUX_MAX_CHANNELS)-1:0] sel_t;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above i_ptr, else lowest request.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_grant,
  output logic [SW-1:0] o_idx,
  output logic          o_any
);

  logic w_found;

  always_comb begin
    w_found = 1'b0;
    o_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_found && i_req[i] && (i >= 32'(i_ptr))) begin
        w_found = 1'b1;
        o_idx   = SW'(i);
      end
    end
    // Nothing at or above the pointer: wrap to the lowest requester.
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_found && i_req[i]) begin
        w_found = 1'b1;
        o_idx   = SW'(i);
      end
    end
    o_any = w_found;
    for (int unsigned i = 0; i < N; i++) begin
      o_grant[i] = i_en && w_found && (SW'(i) == o_idx);
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel round-robin multiplexer with a registered output stage.
// Optional burst lock mode enabled by defining ARB_MUX_LOCK_EN.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter  int unsigned width    = 32,
  parameter  int unsigned channels = 4,
  localparam int unsigned SELW     = sel_width(channels)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [channels-1:0] in_valid,
  input  logic [width-1:0]    in_data [channels],
  output logic [channels-1:0] in_ready,
`ifdef ARB_MUX_LOCK_EN
  input  logic [channels-1:0] in_last,
  output logic                out_last,
`endif
  output logic                out_valid,
  output logic [width-1:0]    out_data,
  output logic [SELW-1:0]     out_sel,
  input  logic                out_ready
);

  logic                r_out_valid;
  logic [width-1:0]    r_out_data;
  logic [SELW-1:0]     r_out_sel;
  logic [SELW-1:0]     r_rr_ptr;
  logic                w_can_load;
  logic                w_any;
  logic [SELW-1:0]     w_idx;
  logic [channels-1:0] w_req;
  logic [channels-1:0] w_grant;
  logic [SELW-1:0]     w_ptr_next;

  assign w_can_load = !r_out_valid || out_ready;
  assign w_ptr_next = SELW'(rr_next(32'(w_idx), channels));

`ifdef ARB_MUX_LOCK_EN
  logic            r_lock;
  logic [SELW-1:0] r_lock_ch;
  logic            r_out_last;

  // While a burst is open only the locked channel may compete.
  always_comb begin
    w_req = in_valid;
    if (r_lock) begin
      w_req            = '0;
      w_req[r_lock_ch] = in_valid[r_lock_ch];
    end
  end

  assign out_last = r_out_last;
`else
  assign w_req = in_valid;
`endif

  rr_arbiter #(
    .N (channels),
    .SW(SELW)
  ) u_rr_arbiter (
    .i_req  (w_req),
    .i_ptr  (r_rr_ptr),
    .i_en   (w_can_load && rst_n),
    .o_grant(w_grant),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign in_ready = w_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_rr_ptr    <= '0;
`ifdef ARB_MUX_LOCK_EN
      r_out_last  <= 1'b0;
      r_lock      <= 1'b0;
      r_lock_ch   <= '0;
`endif
    end else if (w_can_load) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in_data[w_idx];
        r_out_sel   <= w_idx;
`ifdef ARB_MUX_LOCK_EN
        r_out_last  <= in_last[w_idx];
        if (!in_last[w_idx]) begin
          r_lock    <= 1'b1;
          r_lock_ch <= w_idx;
        end else begin
          r_lock    <= 1'b0;
          r_rr_ptr  <= w_ptr_next;
        end
`else
        r_rr_ptr    <= w_ptr_next;
`endif
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux (4 channels, 32-bit) against a behavioural model.
module tb_arb_mux;

  localparam int CH = 4;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] in_valid;
  logic [W-1:0]  in_data [CH];
  logic [CH-1:0] in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [1:0]    out_sel;
  logic          out_ready;
`ifdef ARB_MUX_LOCK_EN
  logic [CH-1:0] in_last;
  logic          out_last;
`endif

  int total = 0;
  int bad   = 0;

  // Model state
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_ptr;
  bit           m_last;
  bit           m_lock;
  int           m_lock_ch;

  arb_mux #(.width(W), .channels(CH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
`ifdef ARB_MUX_LOCK_EN
    .in_last  (in_last),
    .out_last (out_last),
`endif
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic reset_model();
    m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
    m_last = 0; m_lock = 0; m_lock_ch = 0;
  endtask

  function automatic int model_grant();
    if (rst_n !== 1'b1) return -1;
    if (m_lock) return in_valid[m_lock_ch] ? m_lock_ch : -1;
    for (int k = 0; k < CH; k++) begin
      int c;
      c = (m_ptr + k) % CH;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [CH-1:0] exp_ready();
    int g;
    logic [CH-1:0] r;
    g = model_grant();
    r = '0;
    if ((!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Advance one clock and update the model with what the spec says happened at that edge.
  task automatic cycle();
    int g;
    bit load;
    g = model_grant();
    load = !m_valid || out_ready;
    @(posedge clk);
    if (load) begin
      if (g >= 0) begin
        m_valid = 1; m_data = in_data[g]; m_sel = g;
`ifdef ARB_MUX_LOCK_EN
        m_last = in_last[g];
        if (!in_last[g]) begin m_lock = 1; m_lock_ch = g; end
        else begin m_lock = 0; m_ptr = (g + 1) % CH; end
`else
        m_ptr = (g + 1) % CH;
`endif
      end else begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = '1; out_ready = 1'b1;
    for (int i = 0; i < CH; i++) in_data[i] = $urandom;
`ifdef ARB_MUX_LOCK_EN
    in_last = '1;
`endif
    reset_model();
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
    total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", out_sel); end
    total++; if (in_ready !== 4'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_hold_valid got=%0b exp=0", out_valid); end
    in_valid = '0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_fairness();
    in_valid = '1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < CH; c++) in_data[c] = $urandom;
      #1;
      total++; if (in_ready !== exp_ready()) begin bad++; $display("FAIL fair_ready[%0d] got=%b exp=%b", i, in_ready, exp_ready()); end
      cycle();
      total++; if (out_sel !== 2'(i % 4)) begin bad++; $display("FAIL fair_sel[%0d] got=%0d exp=%0d", i, out_sel, i % 4); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fair_valid[%0d] got=%0b exp=1", i, out_valid); end
      total++; if (out_data !== m_data) begin bad++; $display("FAIL fair_data[%0d] got=%h exp=%h", i, out_data, m_data); end
    end
  endtask

  task automatic test_backpressure();
    int hs;
    in_valid = 4'b0100; in_data[2] = 32'hA5A5A5A5; out_ready = 1'b1;
    cycle();
    total++; if (out_data !== 32'hA5A5A5A5 || out_sel !== 2'd2) begin bad++; $display("FAIL bp_load got=%h/%0d exp=a5a5a5a5/2", out_data, out_sel); end
    in_data[2] = 32'h12345678; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 4'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", i, in_ready); end
      cycle();
      total++; if (out_valid !== 1'b1 || out_data !== 32'hA5A5A5A5 || out_sel !== 2'd2) begin
        bad++; $display("FAIL bp_hold[%0d] got=%0b/%h/%0d exp=1/a5a5a5a5/2", i, out_valid, out_data, out_sel); end
    end
    out_ready = 1'b1; hs = 0;
    #1;
    if (in_ready[2] === 1'b1) hs++;
    cycle();
    in_valid = '0;
    #1;
    if (in_ready !== 4'b0) hs++;
    total++; if (hs !== 1) begin bad++; $display("FAIL bp_handshakes got=%0d exp=1", hs); end
    total++; if (out_data !== 32'h12345678) begin bad++; $display("FAIL bp_next_data got=%h exp=12345678", out_data); end
    cycle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%0b exp=0", out_valid); end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    in_valid = 4'b1000; in_data[3] = 32'h33333333;
    cycle();
    total++; if (out_sel !== 2'd3) begin bad++; $display("FAIL wrap_ch3 got=%0d exp=3", out_sel); end
    in_valid = 4'b0110; in_data[1] = 32'h11111111; in_data[2] = 32'h22222222;
    cycle();
    total++; if (out_sel !== 2'd1 || out_data !== 32'h11111111) begin bad++; $display("FAIL wrap_first got=%0d/%h exp=1/11111111", out_sel, out_data); end
    cycle();
    total++; if (out_sel !== 2'd2) begin bad++; $display("FAIL wrap_second got=%0d exp=2", out_sel); end
  endtask

  task automatic test_idle();
    out_ready = 1'b1;
    in_valid = 4'b0001; in_data[0] = 32'hDEADBEEF;
    cycle();
    in_valid = '0; in_data[0] = 32'h0BADF00D;
    cycle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%0b exp=0", out_valid); end
    total++; if (out_data !== 32'hDEADBEEF) begin bad++; $display("FAIL idle_data got=%h exp=deadbeef", out_data); end
  endtask

`ifdef ARB_MUX_LOCK_EN
  task automatic test_lock();
    int exp_sel [6] = '{1, 1, 1, 1, 3, 0};
    int b;
    out_ready = 1'b1; in_last = '1;
    in_valid = 4'b0001; cycle();
    in_valid = '0; cycle();
    b = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = {1'b1, 1'b0, (b < 4), 1'b1};
      in_last = {1'b1, 1'b1, (b == 3), 1'b1};
      for (int c = 0; c < CH; c++) in_data[c] = $urandom;
      cycle();
      if (out_sel == 2'd1) b++;
      total++; if (out_sel !== 2'(exp_sel[i])) begin bad++; $display("FAIL lock_sel[%0d] got=%0d exp=%0d", i, out_sel, exp_sel[i]); end
      total++; if (out_last !== m_last) begin bad++; $display("FAIL lock_last[%0d] got=%0b exp=%0b", i, out_last, m_last); end
    end
    in_valid = '0; in_last = '1; cycle();
  endtask
`endif

  task automatic test_reset_midstall();
    out_ready = 1'b1; in_valid = 4'b0001; in_data[0] = 32'hCAFEF00D;
    cycle();
    out_ready = 1'b0; in_valid = '1;
    cycle();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rms_stall got=%0b exp=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    reset_model();
    total++; if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== 2'd0) begin
      bad++; $display("FAIL rms_async got=%0b/%h/%0d exp=0/0/0", out_valid, out_data, out_sel); end
    total++; if (in_ready !== 4'b0) begin bad++; $display("FAIL rms_in_ready got=%b exp=0000", in_ready); end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 4'b1001; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL rms_first_grant got=%b exp=0001", in_ready); end
    cycle();
    total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL rms_first_sel got=%0d exp=0", out_sel); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      for (int c = 0; c < CH; c++) in_data[c] = $urandom;
`ifdef ARB_MUX_LOCK_EN
      in_last = 4'($urandom);
`endif
      #1;
      total++; if (in_ready !== exp_ready()) begin bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, in_ready, exp_ready()); end
      cycle();
      total++; if (out_valid !== m_valid || out_data !== m_data || out_sel !== 2'(m_sel)) begin
        bad++; $display("FAIL rnd_out[%0d] got=%0b/%h/%0d exp=%0b/%h/%0d", i, out_valid, out_data, out_sel, m_valid, m_data, m_sel); end
`ifdef ARB_MUX_LOCK_EN
      total++; if (out_last !== m_last) begin bad++; $display("FAIL rnd_last[%0d] got=%0b exp=%0b", i, out_last, m_last); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_backpressure();
    test_wrap();
    test_idle();
`ifdef ARB_MUX_LOCK_EN
    test_lock();
`endif
    test_reset_midstall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
